// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and owner-FSM encoding for the unified SRAM port arbiter.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int WEN_W      = 4;
    localparam int CNT_W      = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_IF = 2'd1,
        ST_RD_DM = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_perf_counter.sv
// Free-running, wrapping count of fetch/data conflict cycles.
module arb_perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetches and EX data accesses onto one SRAM port (data wins).
// Optional conflict counter enabled by defining MEM_ARB_PERF_CNT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no read in flight; sram_rdata this cycle belongs to nobody
// ST_RD_IF | fetch read issued last cycle; sram_rdata is the instruction
// ST_RD_DM | data read issued last cycle; sram_rdata is the load data
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,

    input  logic              dm_en,
    input  logic [WEN_W-1:0]  dm_wen,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,

    output logic              sram_en,
    output logic [WEN_W-1:0]  sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,

    output logic              stallreq_for_mem
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  conflict_cnt
`endif
);

    arb_state_e        state_q, state_d;
    logic              grant_dm, grant_if;
    logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;

    always_comb begin
        grant_dm         = dm_en && !rst;
        grant_if         = if_req && !dm_en && !rst;
        stallreq_for_mem = if_req && dm_en && !rst;
        sram_en          = 1'b0;
        sram_wen         = '0;
        sram_addr        = '0;
        sram_wdata       = '0;
        if (grant_dm) begin
            sram_en    = 1'b1;
            sram_wen   = dm_wen;
            sram_addr  = dm_addr;
            sram_wdata = dm_wdata;
        end else if (grant_if) begin
            sram_en    = 1'b1;
            sram_addr  = if_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (if_valid) if_rdata_q <= sram_rdata;
            if (dm_valid) dm_rdata_q <= sram_rdata;
        end
    end

    // Read data is forwarded straight from the SRAM in the return cycle and
    // held in the shadow register afterwards so a stalled stage can resample.
    always_comb begin
        state_d = ST_IDLE;
        if (grant_dm && (dm_wen == '0)) begin
            state_d = ST_RD_DM;
        end else if (grant_if) begin
            state_d = ST_RD_IF;
        end
        if_valid = (state_q == ST_RD_IF) && !rst;
        dm_valid = (state_q == ST_RD_DM) && !rst;
        if_rdata = rst ? '0 : (if_valid ? sram_rdata : if_rdata_q);
        dm_rdata = rst ? '0 : (dm_valid ? sram_rdata : dm_rdata_q);
    end

`ifdef MEM_ARB_PERF_CNT_EN
    arb_perf_counter #(.W(CNT_W)) u_perf_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stallreq_for_mem),
        .cnt (conflict_cnt)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter; the bench plays the SRAM by
// supplying sram_rdata per cycle in the vector table.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_en;
    logic [3:0]  dm_wen;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        stallreq_for_mem;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] conflict_cnt;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_req           (if_req),
        .if_addr          (if_addr),
        .if_rdata         (if_rdata),
        .if_valid         (if_valid),
        .dm_en            (dm_en),
        .dm_wen           (dm_wen),
        .dm_addr          (dm_addr),
        .dm_wdata         (dm_wdata),
        .dm_rdata         (dm_rdata),
        .dm_valid         (dm_valid),
        .sram_en          (sram_en),
        .sram_wen         (sram_wen),
        .sram_addr        (sram_addr),
        .sram_wdata       (sram_wdata),
        .sram_rdata       (sram_rdata),
        .stallreq_for_mem (stallreq_for_mem)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .conflict_cnt     (conflict_cnt)
`endif
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_en;
        logic [3:0]  dm_wen;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [31:0] sram_rdata;
        logic        e_en;
        logic [3:0]  e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_stall;
        logic        e_ifv;
        logic [31:0] e_ifd;
        logic        e_dmv;
        logic [31:0] e_dmd;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string nm, logic r, logic ireq, logic [31:0] iaddr,
                                logic den, logic [3:0] dwen, logic [31:0] daddr,
                                logic [31:0] dwdata, logic [31:0] srd,
                                logic een, logic [3:0] ewen, logic [31:0] eaddr,
                                logic [31:0] ewdata, logic estall, logic eifv,
                                logic [31:0] eifd, logic edmv, logic [31:0] edmd);
        vec_t v;
        v.name = nm; v.rst = r; v.if_req = ireq; v.if_addr = iaddr;
        v.dm_en = den; v.dm_wen = dwen; v.dm_addr = daddr; v.dm_wdata = dwdata;
        v.sram_rdata = srd; v.e_en = een; v.e_wen = ewen; v.e_addr = eaddr;
        v.e_wdata = ewdata; v.e_stall = estall; v.e_ifv = eifv; v.e_ifd = eifd;
        v.e_dmv = edmv; v.e_dmd = edmd;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic r, input logic ireq, input logic [31:0] iaddr,
                         input logic den, input logic [3:0] dwen, input logic [31:0] daddr,
                         input logic [31:0] dwdata, input logic [31:0] srd);
        rst = r; if_req = ireq; if_addr = iaddr; dm_en = den; dm_wen = dwen;
        dm_addr = daddr; dm_wdata = dwdata; sram_rdata = srd;
    endtask

    initial begin
        drive(1'b1, 1'b0, '0, 1'b0, '0, '0, '0, '0);

        //   name          rst ifq if_addr       den wen   dm_addr       dm_wdata      sram_rdata     en wen   addr          wdata         stl ifv if_rdata      dmv dm_rdata
        add("rst_conflict", 1, 1, 32'hBFC00000, 1, 4'h0, 32'h80001000, 32'h0,        32'h0,         0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 32'h0);
        add("rst_fetch",    1, 1, 32'hBFC00000, 0, 4'h0, 32'h0,        32'h0,        32'h0,         0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 32'h0);
        add("first_grant",  0, 1, 32'hBFC00000, 0, 4'h0, 32'h0,        32'h0,        32'h0,         1, 4'h0, 32'hBFC00000, 32'h0,        0, 0, 32'h0,        0, 32'h0);
        add("fetch_ret",    0, 0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        32'h24080001,  0, 4'h0, 32'h0,        32'h0,        0, 1, 32'h24080001, 0, 32'h0);
        add("fetch_hold",   0, 0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        32'hFFFFFFFF,  0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h24080001, 0, 32'h0);
        add("conflict",     0, 1, 32'hBFC00004, 1, 4'h0, 32'h80001000, 32'h11111111, 32'h0,         1, 4'h0, 32'h80001000, 32'h11111111, 1, 0, 32'h24080001, 0, 32'h0);
        add("dm_ret_ifgnt", 0, 1, 32'hBFC00004, 0, 4'h0, 32'h0,        32'h0,        32'h12345678,  1, 4'h0, 32'hBFC00004, 32'h0,        0, 0, 32'h24080001, 1, 32'h12345678);
        add("if_ret_dmgnt", 0, 0, 32'h0,        1, 4'h0, 32'h80002000, 32'h0,        32'h0000AAAA,  1, 4'h0, 32'h80002000, 32'h0,        0, 1, 32'h0000AAAA, 0, 32'h12345678);
        add("dm_ret2",      0, 0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        32'h0000BBBB,  0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0000AAAA, 1, 32'h0000BBBB);
        add("store",        0, 0, 32'h0,        1, 4'hF, 32'h80003000, 32'hDEADBEEF, 32'h0,         1, 4'hF, 32'h80003000, 32'hDEADBEEF, 0, 0, 32'h0000AAAA, 0, 32'h0000BBBB);
        add("store_after",  0, 0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        32'hCAFEF00D,  0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0000AAAA, 0, 32'h0000BBBB);
        add("store_confl",  0, 1, 32'hBFC00008, 1, 4'h3, 32'h80003004, 32'h01020304, 32'h0,         1, 4'h3, 32'h80003004, 32'h01020304, 1, 0, 32'h0000AAAA, 0, 32'h0000BBBB);
        add("fetch_retry",  0, 1, 32'hBFC00008, 0, 4'h0, 32'h0,        32'h0,        32'h99999999,  1, 4'h0, 32'hBFC00008, 32'h0,        0, 0, 32'h0000AAAA, 0, 32'h0000BBBB);
        add("fetch_ret2",   0, 0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        32'h55555555,  0, 4'h0, 32'h0,        32'h0,        0, 1, 32'h55555555, 0, 32'h0000BBBB);
        add("read_b4_rst",  0, 0, 32'h0,        1, 4'h0, 32'h80004000, 32'h0,        32'h0,         1, 4'h0, 32'h80004000, 32'h0,        0, 0, 32'h55555555, 0, 32'h0000BBBB);
        add("rst_mid_read", 1, 1, 32'hBFC0000C, 0, 4'h0, 32'h0,        32'h0,        32'h77777777,  0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 32'h0);
        add("after_rst",    0, 0, 32'h0,        0, 4'h0, 32'h0,        32'h0,        32'h88888888,  0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        0, 32'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].if_req, vecs[i].if_addr, vecs[i].dm_en,
                  vecs[i].dm_wen, vecs[i].dm_addr, vecs[i].dm_wdata, vecs[i].sram_rdata);
            #1;
            chk({vecs[i].name, ".sram_en"},    {31'b0, sram_en},          {31'b0, vecs[i].e_en});
            chk({vecs[i].name, ".sram_wen"},   {28'b0, sram_wen},         {28'b0, vecs[i].e_wen});
            chk({vecs[i].name, ".sram_addr"},  sram_addr,                 vecs[i].e_addr);
            chk({vecs[i].name, ".sram_wdata"}, sram_wdata,                vecs[i].e_wdata);
            chk({vecs[i].name, ".stall"},      {31'b0, stallreq_for_mem}, {31'b0, vecs[i].e_stall});
            chk({vecs[i].name, ".if_valid"},   {31'b0, if_valid},         {31'b0, vecs[i].e_ifv});
            chk({vecs[i].name, ".if_rdata"},   if_rdata,                  vecs[i].e_ifd);
            chk({vecs[i].name, ".dm_valid"},   {31'b0, dm_valid},         {31'b0, vecs[i].e_dmv});
            chk({vecs[i].name, ".dm_rdata"},   dm_rdata,                  vecs[i].e_dmd);
        end

        // Load data must stay put across idle cycles while the SRAM output wanders.
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b1, 4'h0, 32'h80005000, '0, '0);
        #1;
        chk("hold.grant_en",   {31'b0, sram_en}, 32'd1);
        chk("hold.grant_addr", sram_addr,        32'h80005000);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, 4'h0, '0, '0, 32'h12345678);
        #1;
        chk("hold.ret_valid", {31'b0, dm_valid}, 32'd1);
        chk("hold.ret_data",  dm_rdata,          32'h12345678);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            sram_rdata = $urandom;
            #1;
            chk($sformatf("hold%0d.dm_valid", k), {31'b0, dm_valid}, 32'd0);
            chk($sformatf("hold%0d.dm_rdata", k), dm_rdata,          32'h12345678);
            chk($sformatf("hold%0d.if_rdata", k), if_rdata,          32'h0);
        end

`ifdef MEM_ARB_PERF_CNT_EN
        @(negedge clk);
        drive(1'b1, 1'b0, '0, 1'b0, 4'h0, '0, '0, '0);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, 4'h0, '0, '0, '0);
        #1;
        chk("cnt.after_rst", conflict_cnt, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 32'hBFC00000, 1'b1, 4'h0, 32'h80001000, '0, '0);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, 4'h0, '0, '0, '0);
        #1;
        chk("cnt.three", conflict_cnt, 32'd3);
        dut.u_perf_cnt.cnt = 32'hFFFFFFFF;
        @(negedge clk);
        drive(1'b0, 1'b1, 32'hBFC00000, 1'b1, 4'h0, 32'h80001000, '0, '0);
        #1;
        chk("cnt.preload", conflict_cnt, 32'hFFFFFFFF);
        @(negedge clk);
        drive(1'b0, 1'b0, '0, 1'b0, 4'h0, '0, '0, '0);
        #1;
        chk("cnt.wrap", conflict_cnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the address width.
REQ-002 SHALL have parameter DATA_W, default 32, the data width; the byte-enable width is DATA_W/8.
REQ-003 SHALL have ports clk (input, 1, the single clock) and rst (input, 1); reset is synchronous and active-high.
REQ-004 SHALL have if_req (input, 1), the instruction-fetch request, and if_addr (input, ADDR_W), the fetch address.
REQ-005 SHALL have if_rdata (output, DATA_W), the fetched instruction, and if_valid (output, 1), a one-cycle pulse marking fresh if_rdata.
REQ-006 SHALL have dm_en (input, 1), dm_wen (input, 4), dm_addr (input, ADDR_W) and dm_wdata (input, DATA_W), the data-memory access from EX.
REQ-007 SHALL have dm_rdata (output, DATA_W) and dm_valid (output, 1), the load data and its one-cycle valid pulse.
REQ-008 SHALL have sram_en, sram_wen[3:0], sram_addr and sram_wdata as outputs and sram_rdata as an input, forming the single unified SRAM port with 1-cycle read latency.
REQ-009 SHALL have stallreq_for_mem (output, 1), a stall request sent to CTRL.

Function
REQ-010 SHALL grant at most one requester per cycle; a data access (dm_en=1) has priority over a fetch (if_req=1).
REQ-011 SHALL drive the SRAM port combinationally from the granted requester; with no grant, sram_en=0, sram_wen=0, and sram_addr/sram_wdata=0.
REQ-012 SHALL assert stallreq_for_mem combinationally in any cycle where if_req=1 and dm_en=1; this is the only cause of stallreq_for_mem.
REQ-013 SHALL keep an owner FSM with states IDLE, RD_IF and RD_DM, recording the owner of the read issued in the current cycle.
REQ-014 SHALL transition the FSM each cycle to RD_DM on a granted data read (dm_wen=0), to RD_IF on a granted fetch, and to IDLE otherwise, including on data writes.
REQ-015 SHALL, in RD_IF, capture sram_rdata into if_rdata and pulse if_valid=1 for one cycle; in RD_DM, it SHALL do the same with dm_rdata and dm_valid.
REQ-016 SHALL hold if_rdata and dm_rdata at their last captured value until that requester's next read returns, so a stalled pipeline can resample them.
REQ-017 SHALL ignore a fetch while it is denied; the fetch stage re-presents if_req and if_addr, so no fetch state is stored internally.
REQ-018 SHALL make write-only accesses (dm_wen≠0) produce no dm_valid pulse and leave dm_rdata unchanged.
REQ-019 SHALL, for back-to-back reads by alternating owners, return each response exactly one cycle after its grant, independent of the FSM state.

Reset
REQ-020 SHALL, while rst=1, put the FSM in IDLE, force if_valid=0 and dm_valid=0, clear if_rdata and dm_rdata to 0, and force sram_en=0, sram_wen=0 and stallreq_for_mem=0.
REQ-021 SHALL discard a read issued in the cycle rst asserts: no valid pulse appears in the cycle after reset.
REQ-022 SHALL allow the first grant in the first cycle with rst=0.

Configuration
REQ-023 SHALL use macro MEM_ARB_PERF_CNT_EN; when it is defined, the module SHALL add output conflict_cnt (32 bits).
REQ-024 SHALL clear conflict_cnt on reset, increment it by 1 in each cycle with stallreq_for_mem=1, and wrap from 0xFFFFFFFF to 0.
REQ-025 SHALL, when MEM_ARB_PERF_CNT_EN is undefined, omit both the port and the counter logic, with all other behaviour unchanged.

Structure
REQ-026 SHALL place the FSM state encodings (IDLE, RD_IF, RD_DM, 2 bits) as localparams/typedefs in the shared defines header alongside the other bus-width constants.
REQ-027 SHALL use one optional sub-module, arb_perf_counter, for the conflict counter; everything else is flat.
REQ-028 SHALL be instantiated in the core between IF/EX and the memory, with stallreq_for_mem ORed into CTRL's stall generation.

Verification
REQ-029 SHALL verify an isolated fetch: if_req=1 with if_addr=0xBFC00000, SRAM returning 0x24080001 → sram_en=1 in cycle N, if_valid=1 and if_rdata=0x24080001 in cycle N+1.
REQ-030 SHALL verify a conflict: if_req=1 and dm_en=1, dm_addr=0x80001000, dm_wen=0 → sram_addr=0x80001000 and stallreq_for_mem=1 in cycle N; dm_valid=1 and if_valid=0 in cycle N+1; the fetch is granted in N+1 when dm_en=0.
REQ-031 SHALL verify a store: dm_en=1, dm_wen=0xF, dm_wdata=0xDEADBEEF → sram_wen=0xF; no dm_valid pulse; dm_rdata keeps its prior value.
REQ-032 SHALL verify reset mid-read: a read is granted in cycle N with rst=1 in N+1 → if_valid=dm_valid=0 and if_rdata=dm_rdata=0 in N+1 and N+2.
REQ-033 SHALL verify hold: a data read returns 0x12345678, then 5 idle cycles → dm_rdata stays 0x12345678 with dm_valid=0.
REQ-034 SHALL verify, with MEM_ARB_PERF_CNT_EN defined, 3 conflict cycles → conflict_cnt=3; preloaded at 0xFFFFFFFF, one conflict → 0.
